sram_bus_master: RTL and testbench

//  Initiator side of the SRAM bus: turns core load/store requests into en/we/addr/size bus cycles.

---
 rtl/sram_bus_master.sv | 167 ++++++++++++++++
 tb/tb_sram_bus_master.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_master.sv
// sram_bus_master: turns core load/store requests into SRAM bus cycles, steers store lanes, formats load data.
// Optional REQ-phase timeout is compiled in when BUS_MASTER_TIMEOUT_EN is defined.
module sram_bus_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [31:0]           core_addr_i,
  input  logic [1:0]            core_size_i,
  input  logic                  core_unsigned_i,
  input  logic [31:0]           core_wdata_i,
  output logic                  core_gnt_o,
  output logic                  core_rvalid_o,
  output logic [31:0]           core_rdata_o,
  output logic                  core_err_o,
  output logic                  o_bus_en,
  output logic                  o_bus_we,
  output logic [ADDR_WIDTH-1:0] o_bus_addr,
  output logic [1:0]            o_bus_size,
  inout  wire  [31:0]           b_bus_data,
  input  logic                  i_bus_ready
);

  typedef enum logic [1:0] {IDLE, REQ, RDATA} state_t;

  state_t                state, state_nxt;
  logic                  lat_we, lat_unsigned;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [1:0]            lat_size;
  logic [31:0]           lat_wdata;
  logic                  misaligned, accept, reject, timeout, bus_drive;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^core_addr_i[31:ADDR_WIDTH];

  function automatic logic [31:0] steer_store(input logic [31:0] data, input logic [1:0] size);
    case (size)
      2'd0:    steer_store = {4{data[7:0]}};
      2'd1:    steer_store = {2{data[15:0]}};
      default: steer_store = data;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [31:0] data, input logic [1:0] offs,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] shifted;
    shifted = data >> {offs, 3'b000};
    case (size)
      2'd0:    format_load = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    format_load = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: format_load = data;
    endcase
  endfunction

  always_comb begin
    case (core_size_i)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = core_addr_i[0];
      2'd2:    misaligned = |core_addr_i[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign accept = (state == IDLE) && core_req_i && !misaligned;
  assign reject = (state == IDLE) && core_req_i && misaligned;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cnt <= '0;
    else if (accept)
      stall_cnt <= '0;
    else if (state == REQ && !i_bus_ready)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  // The last stalled cycle is the TIMEOUT_CYCLES-th one; abandon the transfer at its closing edge.
  assign timeout = (state == REQ) && !i_bus_ready && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ: begin
        if (i_bus_ready)  state_nxt = lat_we ? IDLE : RDATA;
        else if (timeout) state_nxt = IDLE;
      end
      RDATA:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    core_gnt_o = 1'b0;
    o_bus_en   = 1'b0;
    o_bus_we   = 1'b0;
    o_bus_addr = '0;
    o_bus_size = 2'd0;
    bus_drive  = 1'b0;
    case (state)
      IDLE: core_gnt_o = !rst_i;
      REQ: begin
        o_bus_en   = 1'b1;
        o_bus_we   = lat_we;
        o_bus_addr = lat_addr;
        o_bus_size = lat_size;
        bus_drive  = lat_we;
      end
      default: ;
    endcase
  end

  // Only a write in REQ drives the shared bus, so RDATA always leaves a turnaround cycle.
  assign b_bus_data = bus_drive ? lat_wdata : 'z;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_size     <= 2'd0;
      lat_wdata    <= '0;
    end else if (accept) begin
      lat_we       <= core_we_i;
      lat_unsigned <= core_unsigned_i;
      lat_addr     <= core_addr_i[ADDR_WIDTH-1:0];
      lat_size     <= core_size_i;
      lat_wdata    <= steer_store(core_wdata_i, core_size_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_rvalid_o <= 1'b0;
      core_err_o    <= 1'b0;
      core_rdata_o  <= '0;
    end else begin
      core_rvalid_o <= 1'b0;
      core_err_o    <= 1'b0;
      core_rdata_o  <= '0;
      if (reject || timeout) begin
        core_rvalid_o <= 1'b1;
        core_err_o    <= 1'b1;
      end else if (state == REQ && i_bus_ready && lat_we) begin
        core_rvalid_o <= 1'b1;
      end else if (state == RDATA) begin
        core_rvalid_o <= 1'b1;
        core_rdata_o  <= format_load(b_bus_data, lat_addr[1:0], lat_size, lat_unsigned);
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_master.sv
// tb_sram_bus_master: random and directed load/store traffic against a small SRAM slave model.
// Expected responses come from a reference memory updated from the core-side view of each store.
module tb_sram_bus_master;

  localparam int TB_TIMEOUT = 4;
`ifdef BUS_MASTER_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0, core_we = 1'b0, core_unsigned = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [1:0]  core_size = 2'd0;
  logic        core_gnt, core_rvalid, core_err;
  logic [31:0] core_rdata;
  logic        o_bus_en, o_bus_we;
  logic [15:0] o_bus_addr;
  logic [1:0]  o_bus_size;
  wire  [31:0] b_bus_data;
  logic        i_bus_ready = 1'b0;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  logic        slave_drv = 1'b0;
  logic [31:0] slave_word = '0;
  int          assertions = 0;
  int          failures = 0;
  int          contention = 0;

  sram_bus_master #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_size_i(core_size), .core_unsigned_i(core_unsigned), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .core_err_o(core_err),
    .o_bus_en(o_bus_en), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_size(o_bus_size),
    .b_bus_data(b_bus_data), .i_bus_ready(i_bus_ready)
  );

  always #5 clk = ~clk;

  assign b_bus_data = slave_drv ? slave_word : 32'bz;

  // Slave: writes chosen lanes at the completing edge, drives read data for the following cycle.
  always @(posedge clk) begin
    slave_drv <= 1'b0;
    if (o_bus_en && i_bus_ready) begin
      if (o_bus_we) begin
        case (o_bus_size)
          2'd0:    mem[o_bus_addr[5:2]][8*o_bus_addr[1:0] +: 8] <= b_bus_data[8*o_bus_addr[1:0] +: 8];
          2'd1:    mem[o_bus_addr[5:2]][16*o_bus_addr[1] +: 16] <= b_bus_data[16*o_bus_addr[1] +: 16];
          default: mem[o_bus_addr[5:2]] <= b_bus_data;
        endcase
      end else begin
        slave_drv  <= 1'b1;
        slave_word <= mem[o_bus_addr[5:2]];
      end
    end
  end

  always @(negedge clk)
    if (slave_drv && o_bus_en && o_bus_we) contention++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Entered and left at a negedge; the exit negedge is the response cycle, so a follow-up call is back-to-back.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata, input int stall);
    bit          mis, tmo;
    int          exp_req, exp_lat, lat, n_en;
    logic [31:0] exp_bus, exp_rdata, word, sh;
    mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    tmo = TIMEOUT_ON && !mis && stall >= TB_TIMEOUT;
    exp_req = mis ? 0 : (tmo ? TB_TIMEOUT : stall + 1);
    exp_lat = mis ? 1 : (tmo ? TB_TIMEOUT + 1 : stall + 2 + (we ? 0 : 1));
    exp_bus = (size == 2'd0) ? {4{wdata[7:0]}} : (size == 2'd1) ? {2{wdata[15:0]}} : wdata;
    word = ref_mem[addr[5:2]];
    sh   = word >> (8 * addr[1:0]);
    case (size)
      2'd0:    exp_rdata = uns ? {24'h0, sh[7:0]}  : 32'($signed(sh[7:0]));
      2'd1:    exp_rdata = uns ? {16'h0, sh[15:0]} : 32'($signed(sh[15:0]));
      default: exp_rdata = word;
    endcase
    if (mis || tmo) exp_rdata = 32'h0;
    if (we && !mis && !tmo) begin
      case (size)
        2'd0:    ref_mem[addr[5:2]][8*addr[1:0] +: 8] = wdata[7:0];
        2'd1:    ref_mem[addr[5:2]][16*addr[1] +: 16] = wdata[15:0];
        default: ref_mem[addr[5:2]] = wdata;
      endcase
    end

    core_req = 1'b1; core_we = we; core_addr = addr; core_size = size;
    core_unsigned = uns; core_wdata = wdata;
    checkOutput("gnt", {31'h0, core_gnt}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    core_req = 1'b0;
    lat = 0;
    n_en = 0;
    for (int i = 1; i <= 40; i++) begin
      if (core_rvalid) begin
        lat = i;
        break;
      end
      if (o_bus_en) begin
        checkOutput("bus_we",   {31'h0, o_bus_we}, {31'h0, we});
        checkOutput("bus_addr", {16'h0, o_bus_addr}, {16'h0, addr[15:0]});
        checkOutput("bus_size", {30'h0, o_bus_size}, {30'h0, size});
        if (we) checkOutput("bus_wdata", b_bus_data, exp_bus);
        i_bus_ready = (n_en >= stall);
        n_en++;
      end else begin
        i_bus_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    checkOutput("req_cycles", n_en, exp_req);
    checkOutput("latency", lat, exp_lat);
    checkOutput("err", {31'h0, core_err}, {31'h0, (mis || tmo)});
    if (!we || mis || tmo) checkOutput("rdata", core_rdata, exp_rdata);
  endtask

  task automatic idleCycle();
    @(negedge clk);
    i_bus_ready = 1'($urandom_range(0, 1));
    checkOutput("single_pulse", {31'h0, core_rvalid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_gnt", {31'h0, core_gnt}, 32'd0);
    checkOutput("rst_en", {31'h0, o_bus_en}, 32'd0);
    checkOutput("rst_rvalid", {31'h0, core_rvalid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b1, 32'h0000_0010, 2'd2, 1'b0, 32'hDEADBEEF, 0); idleCycle();
    applyStimulus(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0, 0);        idleCycle();
    applyStimulus(1'b1, 32'h0000_0010, 2'd2, 1'b0, 32'h8899AABB, 0); idleCycle();
    applyStimulus(1'b0, 32'h0000_0013, 2'd0, 1'b0, 32'h0, 0);        idleCycle();
    applyStimulus(1'b0, 32'h0000_0012, 2'd1, 1'b1, 32'h0, 0);        idleCycle();
    applyStimulus(1'b1, 32'h0000_0001, 2'd1, 1'b0, 32'h1234, 0);     idleCycle();
    applyStimulus(1'b0, 32'h0000_0004, 2'd3, 1'b0, 32'h0, 0);        idleCycle();
    applyStimulus(1'b1, 32'h0000_0020, 2'd2, 1'b0, 32'hCAFEF00D, 5); idleCycle();
    applyStimulus(1'b0, 32'h0000_0020, 2'd2, 1'b0, 32'h0, 2);        idleCycle();
    applyStimulus(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0, 0);
    applyStimulus(1'b1, 32'h0000_0011, 2'd0, 1'b0, 32'h0000_0055, 0);
    applyStimulus(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0, 0);        idleCycle();
    applyStimulus(1'b1, 32'h0000_0024, 2'd2, 1'b0, 32'h13572468, 10); idleCycle();

    // Reset in the middle of a stalled store must abort silently.
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h30; core_size = 2'd2; core_wdata = 32'hA5A5A5A5;
    i_bus_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    core_req = 1'b0;
    checkOutput("pre_rst_en", {31'h0, o_bus_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_en", {31'h0, o_bus_en}, 32'd0);
    checkOutput("mid_rst_we", {31'h0, o_bus_we}, 32'd0);
    checkOutput("mid_rst_addr", {16'h0, o_bus_addr}, 32'd0);
    checkOutput("mid_rst_gnt", {31'h0, core_gnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) idleCycle();
    applyStimulus(1'b0, 32'h0000_0030, 2'd2, 1'b0, 32'h0, 0); idleCycle();

    for (int n = 0; n < 150; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5));
      if ($urandom_range(0, 1) == 0) idleCycle();
    end
    idleCycle();

    checkOutput("contention", contention, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
